// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped branch target buffer with 2-bit saturating
//            direction counters. Lookup is combinational from registered
//            state; updates from execute take effect on the next edge. A
//            flush walks the table clearing one valid bit per cycle.
// Ports    : clk              - clock, all state changes on rising edge
//            rst              - asynchronous active-low reset
//            fetch_pc         - PC presented by fetch
//            branch_prediction- predict taken for fetch_pc
//            branch_target    - predicted target (fetch_pc+4 on miss)
//            upd_valid/pc/taken/target/mispredict - resolved branch info
//            flush            - start invalidation walk
//            bp_ready         - low while the walk is in progress
//            upd_count, mispredict_count - only with BP_PERF_CNT_EN
// Options  : `define BP_PERF_CNT_EN adds the two performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        branch_prediction,
  output logic [31:0] branch_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  input  logic        flush,
  output logic        bp_ready
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0] upd_count,
  output logic [31:0] mispredict_count
`endif
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  // Table storage: valid and ctr are reset, tag and target are plain data.
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];

  state_t              state_q;
  logic [IDX_BITS-1:0] flush_idx_q;
  logic                bp_ready_q;

  // Lookup path
  logic [IDX_BITS-1:0] fetch_idx;
  logic [TAG_W-1:0]    fetch_tag;
  logic                fetch_hit;

  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign fetch_tag = fetch_pc[31:IDX_BITS+2];
  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

  assign branch_prediction = fetch_hit && ctr_q[fetch_idx][1] && bp_ready_q;
  assign branch_target     = fetch_hit ? target_q[fetch_idx] : (fetch_pc + 32'd4);
  assign bp_ready          = bp_ready_q;

  // Update path
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  logic                upd_hit;

  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign upd_tag = upd_pc[31:IDX_BITS+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Byte-offset bits never participate; mispredict only feeds the counters.
  logic unused_bits;
  assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_mispredict};

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (state_q == S_FLUSH) begin
      // Updates arriving during the walk are dropped.
      valid_d[flush_idx_q] = 1'b0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'd3) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          target_d[upd_idx] = upd_target;
        end else begin
          if (ctr_q[upd_idx] != 2'd0) ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocate weakly taken; not-taken misses leave the table alone.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = 2'd2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'd0;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  // Flush walk controller; flush requests during the walk are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      flush_idx_q <= '0;
      bp_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            state_q     <= S_FLUSH;
            flush_idx_q <= '0;
            bp_ready_q  <= 1'b0;
          end
        end
        S_FLUSH: begin
          flush_idx_q <= flush_idx_q + {{(IDX_BITS-1){1'b0}}, 1'b1};
          if (flush_idx_q == {IDX_BITS{1'b1}}) begin
            state_q    <= S_IDLE;
            bp_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          bp_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef BP_PERF_CNT_EN
  // Counters see every update pulse, including ones dropped during a flush.
  logic [31:0] upd_count_q, upd_count_d;
  logic [31:0] mis_count_q, mis_count_d;

  always_comb begin
    upd_count_d = upd_count_q;
    mis_count_d = mis_count_q;
    if (upd_valid) begin
      upd_count_d = upd_count_q + 32'd1;
      if (upd_mispredict) mis_count_d = mis_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_count_q <= 32'd0;
      mis_count_q <= 32'd0;
    end else begin
      upd_count_q <= upd_count_d;
      mis_count_q <= mis_count_d;
    end
  end

  assign upd_count        = upd_count_q;
  assign mispredict_count = mis_count_q;
`endif

endmodule
`default_nettype wire
